// File: rtl/tri_wave_pkg.sv
// Shared types and default widths for the triangle-wave sequencer.
// Optional dwell states are enabled by the TRI_WAVE_HOLD_EN macro.
package tri_wave_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_HOLD_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
    DONE
`ifdef TRI_WAVE_HOLD_EN
    ,
    HOLD_TOP,
    HOLD_BOT
`endif
  } state_t;

  typedef enum logic [1:0] {
    DP_KEEP,
    DP_CLEAR,
    DP_RISE,
    DP_FALL
  } dp_op_t;

endpackage

// File: rtl/tri_step_datapath.sv
// Saturating up/down value register for the triangle-wave sequencer.
// Reports whether the next rise reaches peak or the next fall reaches zero.
module tri_step_datapath
  import tri_wave_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  dp_op_t           op,
  input  logic [WIDTH-1:0] peak,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] value,
  output logic             at_top,
  output logic             at_bot
);

  // One extra bit keeps value+step from wrapping before the compare.
  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, value} + {1'b0, step};
    at_top = (sum >= {1'b0, peak});
    at_bot = (value <= step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      case (op)
        DP_CLEAR: value <= '0;
        DP_RISE:  value <= at_top ? peak : sum[WIDTH-1:0];
        DP_FALL:  value <= at_bot ? '0 : value - step;
        default:  value <= value;
      endcase
    end
  end

endmodule

// File: rtl/tri_wave_sequencer.sv
// Triangle-wave sequencer: runs cmd_cycles up/down ramps between 0 and peak.
// Defining TRI_WAVE_HOLD_EN adds dwell states at peak and between periods.
module tri_wave_sequencer
  import tri_wave_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_peak,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [CNT_W-1:0]  cmd_cycles,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [WIDTH-1:0]  value,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t           state;
  state_t           nxt;
  dp_op_t           op;
  logic [WIDTH-1:0] peak_r;
  logic [WIDTH-1:0] step_r;
  logic [CNT_W-1:0] cyc_left;
  logic             accept;
  logic             bad;
  logic             reject;
  logic             at_top;
  logic             at_bot;

`ifdef TRI_WAVE_HOLD_EN
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_cnt;
`else
  logic unused_hold;
  assign unused_hold = ^cmd_hold;
`endif

  tri_step_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .op     (op),
    .peak   (peak_r),
    .step   (step_r),
    .value  (value),
    .at_top (at_top),
    .at_bot (at_bot)
  );

  always_comb begin
    accept = cmd_valid && cmd_ready && (state == IDLE);
    bad    = (cmd_step == '0) || (cmd_cycles == '0) || (cmd_step > cmd_peak);
    nxt    = state;
    op     = DP_KEEP;
    reject = 1'b0;
    if (abort && state != IDLE) begin
      nxt = IDLE;
      op  = DP_CLEAR;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad) begin
              reject = 1'b1;
            end else begin
              nxt = UP;
              op  = DP_CLEAR;
            end
          end
        end
        UP: begin
          op = DP_RISE;
          if (at_top) begin
`ifdef TRI_WAVE_HOLD_EN
            nxt = (hold_r != '0) ? HOLD_TOP : DOWN;
`else
            nxt = DOWN;
`endif
          end
        end
        DOWN: begin
          op = DP_FALL;
          if (at_bot) begin
            if (cyc_left == CNT_W'(1)) begin
              nxt = DONE;
            end else begin
`ifdef TRI_WAVE_HOLD_EN
              nxt = (hold_r != '0) ? HOLD_BOT : UP;
`else
              nxt = UP;
`endif
            end
          end
        end
        DONE: nxt = IDLE;
`ifdef TRI_WAVE_HOLD_EN
        HOLD_TOP: if (hold_cnt == HOLD_W'(1)) nxt = DOWN;
        HOLD_BOT: if (hold_cnt == HOLD_W'(1)) nxt = UP;
`endif
        default: nxt = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      dir       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      peak_r    <= '0;
      step_r    <= '0;
      cyc_left  <= '0;
`ifdef TRI_WAVE_HOLD_EN
      hold_r    <= '0;
      hold_cnt  <= '0;
`endif
    end else begin
      state     <= nxt;
      cmd_ready <= (nxt == IDLE);
      busy      <= (nxt != IDLE);
      dir       <= (nxt == UP);
      done      <= (nxt == DONE);
      err       <= reject;
      if (accept && !bad) begin
        peak_r   <= cmd_peak;
        step_r   <= cmd_step;
        cyc_left <= cmd_cycles;
`ifdef TRI_WAVE_HOLD_EN
        hold_r   <= cmd_hold;
`endif
      end
      if (state == DOWN && at_bot && cyc_left != CNT_W'(1)) begin
        cyc_left <= cyc_left - 1'b1;
      end
`ifdef TRI_WAVE_HOLD_EN
      // Counter reloads every ramp cycle, so it is full on entry to a dwell.
      if (state == UP || state == DOWN) begin
        hold_cnt <= hold_r;
      end else if (state == HOLD_TOP || state == HOLD_BOT) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_tri_wave_sequencer.sv
// Directed bench for tri_wave_sequencer; dwell checks follow TRI_WAVE_HOLD_EN.
module tb_tri_wave_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_peak;
  logic [7:0] cmd_step;
  logic [7:0] cmd_cycles;
  logic [3:0] cmd_hold;
  logic       abort;
  logic [7:0] value;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  int ramp_v[8]  = '{1, 2, 3, 4, 3, 2, 1, 0};
  int sat_v[12]  = '{100, 200, 250, 150, 50, 0, 100, 200, 250, 150, 50, 0};
`ifdef TRI_WAVE_HOLD_EN
  int dwell_v[17] = '{1, 2, 2, 2, 2, 1, 0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 0};
`else
  int dwell_v[8]  = '{1, 2, 1, 0, 1, 2, 1, 0};
`endif

  tri_wave_sequencer #(
    .WIDTH (8),
    .CNT_W (8),
    .HOLD_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_peak  (cmd_peak),
    .cmd_step  (cmd_step),
    .cmd_cycles(cmd_cycles),
    .cmd_hold  (cmd_hold),
    .abort     (abort),
    .value     (value),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int p, input int s, input int c, input int h);
    cmd_peak   = 8'(p);
    cmd_step   = 8'(s);
    cmd_cycles = 8'(c);
    cmd_hold   = 4'(h);
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_peak = '0; cmd_step = '0;
    cmd_cycles = '0; cmd_hold = '0; abort = 1'b0;
    #12;
    chk("rst_value", 32'(value), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(cmd_ready), 1);
    chk("rel_busy", 32'(busy), 0);

    // basic ramp
    send(4, 1, 1, 0);
    chk("acc_value", 32'(value), 0);
    chk("acc_busy", 32'(busy), 1);
    chk("acc_dir", 32'(dir), 1);
    chk("acc_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ramp_v%0d", i), 32'(value), 32'(ramp_v[i]));
      chk($sformatf("ramp_dir%0d", i), 32'(dir), (i < 3) ? 1 : 0);
      chk($sformatf("ramp_done%0d", i), 32'(done), (i == 7) ? 1 : 0);
    end
    tick();
    chk("ramp_done_end", 32'(done), 0);
    chk("ramp_ready_end", 32'(cmd_ready), 1);
    chk("ramp_busy_end", 32'(busy), 0);
    tick();
    chk("ramp_done_once", 32'(done), 0);

    // saturation, two periods
    send(250, 100, 2, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("sat_v%0d", i), 32'(value), 32'(sat_v[i]));
      chk($sformatf("sat_done%0d", i), 32'(done), (i == 11) ? 1 : 0);
    end
    tick();
    chk("sat_ready_end", 32'(cmd_ready), 1);

    // peak == step
    send(5, 5, 1, 0);
    tick();
    chk("eq_top", 32'(value), 5);
    tick();
    chk("eq_bot", 32'(value), 0);
    chk("eq_done", 32'(done), 1);
    tick();

    // rejected commands
    send(4, 0, 1, 0);
    chk("rej0_err", 32'(err), 1);
    chk("rej0_busy", 32'(busy), 0);
    chk("rej0_value", 32'(value), 0);
    chk("rej0_ready", 32'(cmd_ready), 1);
    tick();
    chk("rej0_err_clr", 32'(err), 0);
    send(3, 5, 1, 0);
    chk("rej1_err", 32'(err), 1);
    chk("rej1_busy", 32'(busy), 0);
    tick();
    chk("rej1_err_clr", 32'(err), 0);
    send(4, 1, 0, 0);
    chk("rej2_err", 32'(err), 1);
    chk("rej2_busy", 32'(busy), 0);
    chk("rej2_value", 32'(value), 0);
    tick();
    chk("rej2_err_clr", 32'(err), 0);

    // abort during DOWN at value 2
    send(4, 1, 1, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("abt_pre", 32'(value), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_value", 32'(value), 0);
    chk("abt_busy", 32'(busy), 0);
    chk("abt_ready", 32'(cmd_ready), 1);
    chk("abt_done", 32'(done), 0);
    tick();
    chk("abt_done2", 32'(done), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_idle_ready", 32'(cmd_ready), 1);
    chk("abt_idle_busy", 32'(busy), 0);

    // cmd_valid held while busy
    send(4, 1, 1, 0);
    cmd_peak = 8'd9; cmd_step = 8'd3; cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("bsy_v%0d", i), 32'(value), 32'(ramp_v[i]));
      chk($sformatf("bsy_ready%0d", i), 32'(cmd_ready), 0);
    end
    chk("bsy_done", 32'(done), 1);
    cmd_valid = 1'b0;
    tick();
    chk("bsy_idle", 32'(busy), 0);
    tick();
    chk("bsy_stay_idle", 32'(busy), 0);

    // dwell scenario; hold ignored unless TRI_WAVE_HOLD_EN
    send(2, 1, 2, 3);
    for (int i = 0; i < $size(dwell_v); i++) begin
      tick();
      chk($sformatf("dw_v%0d", i), 32'(value), 32'(dwell_v[i]));
      chk($sformatf("dw_done%0d", i), 32'(done), (i == $size(dwell_v) - 1) ? 1 : 0);
    end
    tick();
    chk("dw_ready_end", 32'(cmd_ready), 1);

    // asynchronous reset mid-waveform
    send(4, 1, 1, 0);
    tick();
    tick();
    chk("mr_pre", 32'(value), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_value", 32'(value), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_dir", 32'(dir), 0);
    chk("mr_done", 32'(done), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mr_nodone%0d", i), 32'(done), 0);
      chk($sformatf("mr_noerr%0d", i), 32'(err), 0);
      chk($sformatf("mr_idle%0d", i), 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_wave_sequencer.md
TRI_WAVE_SEQUENCER -- requirements
Module: tri_wave_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the waveform value width.
REQ-002 The block SHALL have parameter CNT_W, default 8, the cycle-count width.
REQ-003 The block SHALL have parameter HOLD_W, default 4, the dwell-count width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL provide the following ports:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_peak  in  WIDTH  waveform peak.
- cmd_step  in  WIDTH  increment/decrement per cycle.
- cmd_cycles  in  CNT_W  number of up-down periods.
- cmd_hold  in  HOLD_W  dwell cycles at peak and trough.
- abort  in  1  stop the waveform immediately.
- value  out  WIDTH  waveform sample.
- dir  out  1  1 = ramping up, 0 = otherwise.
- busy  out  1  waveform in progress.
- done  out  1  one-cycle pulse at normal completion.
- err  out  1  one-cycle pulse on a rejected command.

Function
REQ-006 The FSM SHALL have states IDLE, UP, DOWN and DONE, plus HOLD_TOP and HOLD_BOT when the macro in REQ-020 is defined.
REQ-007 cmd_ready SHALL be 1 only in IDLE; cmd_valid is ignored in every other state.
REQ-008 A command accepted with cmd_step==0, cmd_cycles==0 or cmd_step>cmd_peak SHALL pulse err for one cycle and leave the FSM in IDLE.
REQ-009 A legal acceptance SHALL latch peak, step, cycles and hold, and SHALL go to UP on the same edge with value=0.
REQ-010 In UP, at each edge:
- if value+step>=peak: value<=peak, go to DOWN (or HOLD_TOP);
- else value<=value+step.
The sum SHALL be computed in WIDTH+1 bits, so no wrap-around occurs.
REQ-011 In DOWN, at each edge:
- if value<=step: value<=0; if the remaining cycle count is 1, go to DONE; else decrement it and go to UP (or HOLD_BOT);
- else value<=value-step.
Value SHALL never underflow.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL then go to IDLE; value stays 0.
REQ-013 busy SHALL be 1 in every state except IDLE; dir SHALL be 1 only in UP.
REQ-014 abort high in any state other than IDLE SHALL force IDLE and value=0 on the next edge, with no done pulse; abort in IDLE has no effect.
REQ-015 abort has priority over all other transitions, including the DONE transition.
REQ-016 When peak==step, UP SHALL reach peak in one edge and DOWN SHALL reach 0 in one edge.

Reset
REQ-017 While rst_n is low, all outputs SHALL be held at the following values:
- state=IDLE, value=0, dir=0, busy=0, done=0, err=0;
- cmd_ready=1 after release.
REQ-018 Reset asserted mid-waveform SHALL discard the latched command, and no done or err pulse SHALL follow.
REQ-019 Reset release SHALL take effect synchronously at the first clk edge after rst_n rises.

Configuration
REQ-020 With TRI_WAVE_HOLD_EN defined, the dwell states SHALL be active:
- HOLD_TOP holds value=peak for cmd_hold cycles before DOWN;
- HOLD_BOT holds value=0 for cmd_hold cycles between periods, but not after the final period;
- cmd_hold==0 skips the dwell state entirely.
REQ-021 Without TRI_WAVE_HOLD_EN, the hold states and hold counter SHALL be absent, and cmd_hold SHALL remain a port that is ignored.

Structure
REQ-022 Package tri_wave_pkg SHALL hold the state enum type and the default WIDTH, CNT_W and HOLD_W constants.
REQ-023 The saturating up/down datapath (value register, add/sub, compare) SHALL be a sub-module named tri_step_datapath, sequenced by the FSM in tri_wave_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Basic ramp: peak=4, step=1, cycles=1, no hold -> value 1,2,3,4,3,2,1,0 on successive edges, then done pulses exactly once and cmd_ready returns next cycle.
- Saturation and wrap: peak=250, step=100, cycles=2 -> values 100,200,250,150,50,0 twice, with no wrap past 255.
- Rejected commands: step=0, then step=5 with peak=3, then cycles=0 -> err pulses each time, busy stays 0, value stays 0.
- Abort and busy commands: abort during DOWN at value=2 -> value=0 and IDLE next edge, no done; cmd_valid held during busy -> never accepted.
- Dwell (TRI_WAVE_HOLD_EN): peak=2, step=1, cycles=2, hold=3 -> value 2 held 3 extra cycles each peak, 0 held 3 cycles only between periods.
- Reset mid-waveform: rst_n low during UP -> all outputs reset immediately (asynchronous), no done after release.
